// File: rtl/risc32_if_stage_pkg.sv
// Shared definitions for the risc32 instruction-fetch stage: bus widths,
// chip-enable levels, the bubble word, the sequential fetch step and the
// encodings used by the FSM, the PC mux and the IF/ID register.
package risc32_if_stage_pkg;

    // Instruction address and instruction word widths
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // ROM chip-enable levels
    localparam logic CHIP_EN  = 1'b1;
    localparam logic CHIP_DIS = 1'b0;

    // All-zero word; a bubble in IF/ID is simply this word with valid low
    localparam logic [31:0]       WORD_ZERO   = 32'h0000_0000;
    localparam logic [INST_W-1:0] BUBBLE_INST = WORD_ZERO;

    // Byte increment between sequential fetches
    localparam logic [INST_ADDR_W-1:0] PC_STEP_BYTES = 32'd4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } if_state_t;

    // Source selection for the next PC
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_FLUSH  = 2'd3
    } pc_sel_t;

    // What the IF/ID register does on the next edge
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

    // Instructions are word aligned; anything with low bits set is illegal
    function automatic logic word_aligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/risc32_pc_reg.sv
// Program counter for the fetch stage: holds the PC, selects the next PC
// from hold / sequential / branch / flush sources and reports whether the
// branch or flush target is misaligned. A misaligned target is never loaded,
// even if selected, so the PC always stays word aligned.
module risc32_pc_reg
    import risc32_if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = PC_STEP_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  pc_sel_t                pc_sel,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic [INST_ADDR_W-1:0] flush_target,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   branch_misaligned,
    output logic                   flush_misaligned
);

    logic [INST_ADDR_W-1:0] next_pc;

    // Alignment checks on both redirect targets
    always_comb begin
        branch_misaligned = !word_aligned(branch_target);
        flush_misaligned  = !word_aligned(flush_target);
    end

    // Next-PC mux; sequential fetch wraps naturally at the top of memory
    always_comb begin
        next_pc = pc;
        case (pc_sel)
            PC_HOLD:   next_pc = pc;
            PC_SEQ:    next_pc = pc + PC_STEP;
            PC_BRANCH: next_pc = branch_misaligned ? pc : branch_target;
            PC_FLUSH:  next_pc = flush_misaligned ? pc : flush_target;
            default:   next_pc = pc;
        endcase
    end

    // PC register with asynchronous reset to the boot address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/risc32_if_stage.sv
// Instruction-fetch stage of the risc32 pipeline. Drives the ROM enable and
// address from the PC, captures the ROM's combinational output into IF/ID,
// and handles stall, delayed branch, flush, halt and misaligned targets.
module risc32_if_stage
    import risc32_if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = PC_STEP_BYTES
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_target_i,
    input  logic                   halt_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o,
    output logic                   fetch_err_o
);

    if_state_t              state;
    if_state_t              next_state;
    pc_sel_t                pc_sel;
    ifid_op_t               ifid_op;
    logic                   set_err;
    logic [INST_ADDR_W-1:0] pc;
    logic                   branch_misaligned;
    logic                   flush_misaligned;

    risc32_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk               (clk_i),
        .rst_n             (rst_n_i),
        .pc_sel            (pc_sel),
        .branch_target     (branch_target_i),
        .flush_target      (flush_target_i),
        .pc                (pc),
        .branch_misaligned (branch_misaligned),
        .flush_misaligned  (flush_misaligned)
    );

    assign rom_addr_o = pc;

    // Next-state and control decode: flush first, then halt, stall, branch, sequential
    always_comb begin
        next_state = state;
        pc_sel     = PC_HOLD;
        ifid_op    = IFID_HOLD;
        set_err    = 1'b0;

        if (flush_i) begin
            ifid_op = IFID_BUBBLE;
            if (flush_misaligned) begin
                set_err    = 1'b1;
                next_state = S_HALT;
            end else begin
                pc_sel     = PC_FLUSH;
                next_state = S_RUN;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    next_state = S_RUN;
                end
                S_RUN: begin
                    if (halt_i) begin
                        next_state = S_HALT;
                        ifid_op    = IFID_BUBBLE;
                    end else if (stall_i) begin
                        // ID keeps presenting the branch, so nothing moves here
                        ifid_op = IFID_HOLD;
                    end else if (branch_flag_i) begin
                        if (branch_misaligned) begin
                            set_err    = 1'b1;
                            next_state = S_HALT;
                            ifid_op    = IFID_BUBBLE;
                        end else begin
                            // The delay-slot instruction is captured, never squashed
                            ifid_op = IFID_LOAD;
                            pc_sel  = PC_BRANCH;
                        end
                    end else begin
                        ifid_op = IFID_LOAD;
                        pc_sel  = PC_SEQ;
                    end
                end
                S_HALT: begin
                    ifid_op = IFID_BUBBLE;
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    // State register and registered ROM chip enable (enabled only while running)
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            rom_ce_o <= CHIP_DIS;
        end else begin
            state    <= next_state;
            rom_ce_o <= (next_state == S_RUN) ? CHIP_EN : CHIP_DIS;
        end
    end

    // IF/ID pipeline register: load the fetched word, insert a bubble, or hold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_pc_o    <= WORD_ZERO;
            id_inst_o  <= BUBBLE_INST;
            id_valid_o <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_LOAD: begin
                    id_pc_o    <= pc;
                    id_inst_o  <= inst_i;
                    id_valid_o <= 1'b1;
                end
                IFID_BUBBLE: begin
                    id_pc_o    <= WORD_ZERO;
                    id_inst_o  <= BUBBLE_INST;
                    id_valid_o <= 1'b0;
                end
                default: begin
                    id_pc_o    <= id_pc_o;
                    id_inst_o  <= id_inst_o;
                    id_valid_o <= id_valid_o;
                end
            endcase
        end
    end

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_err_o <= 1'b0;
        end else if (set_err) begin
            fetch_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_risc32_if_stage.sv
// Self-checking bench for risc32_if_stage: a ROM model answers the DUT's
// address, a behavioural model of the fetch stage predicts every output,
// and directed phases pin the model with hand-computed literal values
// before a randomized run.
module tb_risc32_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_target_i = 32'h0;
    logic        halt_i = 1'b0;
    logic [31:0] inst_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        fetch_err_o;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: fetch mode plus the visible registers
    localparam int MODE_WAKE    = 0;
    localparam int MODE_FETCH   = 1;
    localparam int MODE_STOPPED = 2;
    int          m_mode = MODE_WAKE;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_id_pc = 32'h0;
    logic [31:0] m_id_inst = 32'h0;
    logic        m_id_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_ce = 1'b0;

    risc32_if_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .halt_i          (halt_i),
        .inst_i          (inst_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .fetch_err_o     (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM contents: a few fixed words, otherwise an address-derived pattern
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h3c01_0000;
            32'h0000_0004: return 32'h3421_f000;
            32'h0000_001C: return 32'h201d_0000;
            default:       return {addr[15:0] ^ 16'h5a5a, addr[31:16] + 16'h1357};
        endcase
    endfunction

    assign inst_i = rom_word(rom_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = MODE_WAKE;
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
        m_err      = 1'b0;
        m_ce       = 1'b0;
    endtask

    task automatic model_bubble();
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
    endtask

    task automatic model_capture();
        m_id_pc    = m_pc;
        m_id_inst  = rom_word(m_pc);
        m_id_valid = 1'b1;
    endtask

    // One clock edge of the fetch stage as described behaviourally
    task automatic model_step();
        if (flush_i) begin
            model_bubble();
            if (flush_target_i % 4 != 0) begin
                m_err  = 1'b1;
                m_mode = MODE_STOPPED;
            end else begin
                m_pc   = flush_target_i;
                m_mode = MODE_FETCH;
            end
        end else if (m_mode == MODE_WAKE) begin
            m_mode = MODE_FETCH;
        end else if (m_mode == MODE_STOPPED) begin
            model_bubble();
        end else if (halt_i) begin
            m_mode = MODE_STOPPED;
            model_bubble();
        end else if (stall_i) begin
            m_mode = MODE_FETCH;
        end else if (branch_flag_i) begin
            if (branch_target_i % 4 != 0) begin
                m_err  = 1'b1;
                m_mode = MODE_STOPPED;
                model_bubble();
            end else begin
                model_capture();
                m_pc = branch_target_i;
            end
        end else begin
            model_capture();
            m_pc = (m_pc + 32'd4) & 32'hFFFF_FFFF;
        end
        m_ce = (m_mode == MODE_FETCH);
    endtask

    // Model follows the clock and the asynchronous reset
    always @(posedge clk_i) if (rst_n_i) model_step();
    always @(negedge rst_n_i) model_reset();

    // Compare every DUT output with the model once per cycle
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("rom_ce", {31'h0, rom_ce_o}, {31'h0, m_ce});
            check("rom_addr", rom_addr_o, m_pc);
            check("id_pc", id_pc_o, m_id_pc);
            check("id_inst", id_inst_o, m_id_inst);
            check("id_valid", {31'h0, id_valid_o}, {31'h0, m_id_valid});
            check("fetch_err", {31'h0, fetch_err_o}, {31'h0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] bt,
                                 input logic fl, input logic [31:0] ft, input logic ht);
        stall_i         = st;
        branch_flag_i   = br;
        branch_target_i = bt;
        flush_i         = fl;
        flush_target_i  = ft;
        halt_i          = ht;
    endtask

    task automatic idle_inputs();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] bt;
        logic [31:0] ft;
        // Hold reset a few cycles, then release between edges
        repeat (3) @(negedge clk_i);
        cmp_en = 1'b1;
        rst_n_i = 1'b1;
        #1;
        check("lit_ce_idle", {31'h0, rom_ce_o}, 32'h0);
        check("lit_valid_reset", {31'h0, id_valid_o}, 32'h0);

        // Reset release: one disabled cycle, then sequential fetch from 0
        tick();
        check("lit_ce_run", {31'h0, rom_ce_o}, 32'h1);
        check("lit_addr0", rom_addr_o, 32'h0);
        tick();
        check("lit_inst0", id_inst_o, 32'h3c01_0000);
        check("lit_pc0", id_pc_o, 32'h0);
        check("lit_valid_first", {31'h0, id_valid_o}, 32'h1);
        tick();
        check("lit_inst4", id_inst_o, 32'h3421_f000);
        check("lit_pc4", id_pc_o, 32'h4);

        // Run sequentially up to 0x1C, then branch to 0x0C with a delay slot
        for (int i = 0; i < 20 && m_pc != 32'h1C; i++) tick();
        check("lit_reach_1c", rom_addr_o, 32'h1C);
        applyStimulus(1'b0, 1'b1, 32'h0C, 1'b0, 32'h0, 1'b0);
        tick();
        check("lit_slot_pc", id_pc_o, 32'h1C);
        check("lit_slot_inst", id_inst_o, 32'h201d_0000);
        check("lit_slot_valid", {31'h0, id_valid_o}, 32'h1);
        check("lit_branch_addr", rom_addr_o, 32'h0C);

        // Stall three cycles with a branch pending; nothing may move
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_stall_addr", rom_addr_o, 32'h0C);
            check("lit_stall_idpc", id_pc_o, 32'h1C);
            check("lit_stall_inst", id_inst_o, 32'h201d_0000);
        end
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        tick();
        check("lit_post_stall_addr", rom_addr_o, 32'h40);
        check("lit_post_stall_idpc", id_pc_o, 32'h0C);
        idle_inputs();
        tick();
        check("lit_branch_once", rom_addr_o, 32'h44);
        check("lit_branch_once_idpc", id_pc_o, 32'h40);

        // Flush beats stall
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        tick();
        check("lit_flush_valid", {31'h0, id_valid_o}, 32'h0);
        check("lit_flush_inst", id_inst_o, 32'h0);
        check("lit_flush_addr", rom_addr_o, 32'h100);
        idle_inputs();
        tick();
        check("lit_after_flush_idpc", id_pc_o, 32'h100);

        // Misaligned branch target halts with a sticky error
        applyStimulus(1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0);
        tick();
        check("lit_err_set", {31'h0, fetch_err_o}, 32'h1);
        check("lit_err_ce", {31'h0, rom_ce_o}, 32'h0);
        check("lit_err_valid", {31'h0, id_valid_o}, 32'h0);
        check("lit_err_pc_held", rom_addr_o, 32'h104);
        idle_inputs();
        tick();
        check("lit_halt_ce", {31'h0, rom_ce_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        tick();
        check("lit_resume_ce", {31'h0, rom_ce_o}, 32'h1);
        check("lit_resume_addr", rom_addr_o, 32'h0);
        check("lit_err_sticky", {31'h0, fetch_err_o}, 32'h1);
        idle_inputs();
        tick();
        check("lit_resume_inst", id_inst_o, 32'h3c01_0000);

        // Wrap at the top of memory
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        check("lit_top_addr", rom_addr_o, 32'hFFFF_FFFC);
        idle_inputs();
        tick();
        check("lit_wrap_addr", rom_addr_o, 32'h0);
        check("lit_wrap_idpc", id_pc_o, 32'hFFFF_FFFC);

        // Asynchronous reset mid-cycle clears everything immediately
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("lit_async_ce", {31'h0, rom_ce_o}, 32'h0);
        check("lit_async_addr", rom_addr_o, 32'h0);
        check("lit_async_idpc", id_pc_o, 32'h0);
        check("lit_async_inst", id_inst_o, 32'h0);
        check("lit_async_valid", {31'h0, id_valid_o}, 32'h0);
        check("lit_async_err", {31'h0, fetch_err_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 800; i++) begin
            bt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            ft = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) ft[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) ft = 32'hFFFF_FFF8;
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0, bt,
                          $urandom_range(0, 15) == 0, ft,
                          $urandom_range(0, 39) == 0);
            tick();
        end
        idle_inputs();
        tick();
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
